// File: rtl/event_encoder_pkg.sv
// -----------------------------------------------------------------------------
// event_encoder_pkg
// Shared widths, the controller state type and a popcount helper for the
// event encoder and its priority-encoder sub-module.
// -----------------------------------------------------------------------------
package event_encoder_pkg;

  localparam int EV_W   = 8;  // number of event lines
  localparam int CODE_W = 3;  // width of an event index
  localparam int CNT_W  = 4;  // holds 0..EV_W

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  // Number of set bits in an event vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [EV_W-1:0] v);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < EV_W; i++) begin
      sum = sum + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// -----------------------------------------------------------------------------
// prio_enc8
// Combinational 8-to-3 priority encoder; bit 7 has the highest priority.
//
// Ports:
//   vec  in  [7:0]  request vector
//   idx  out [2:0]  index of the highest set bit (0 when vec is 0)
//   any  out        at least one bit of vec is set
// -----------------------------------------------------------------------------
module prio_enc8
  import event_encoder_pkg::*;
(
  input  logic [EV_W-1:0]   vec,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  always_comb begin
    // NOTE: give every combinational output a default before any conditional
    // assignment; otherwise the tool infers a latch to hold the old value.
    idx = '0;
    any = |vec;
    // Ascending scan: the last hit is the highest set bit, so it wins.
    for (int i = 0; i < EV_W; i++) begin
      if (vec[i]) idx = CODE_W'(i);
    end
  end

endmodule

// File: rtl/event_encoder.sv
// -----------------------------------------------------------------------------
// event_encoder
// Captures level events into a pending register and hands them out one at a
// time, highest index first, over a valid/ready interface.
//
// Ports:
//   clk    in        clock, rising edge
//   rst_n  in        asynchronous active-low reset
//   ev     in  [7:0] event lines, sampled every cycle when en=1
//   en     in        capture enable
//   clr    in        synchronous clear of pending, ovf and any presentation
//   code   out [2:0] index of the presented event (registered)
//   valid  out       code holds a presented event (registered)
//   ready  in        consumer takes code when valid & ready at a clk edge
//   cnt    out [3:0] number of pending events, including the presented one
//   ovf    out       sticky: an event hit a bit that was already pending
// -----------------------------------------------------------------------------
module event_encoder
  import event_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [EV_W-1:0]   ev,
  input  logic              en,
  input  logic              clr,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic [CNT_W-1:0]  cnt,
  output logic              ovf
);

  state_t            state;
  logic [EV_W-1:0]   pending;

  logic [EV_W-1:0]   taken;
  logic [EV_W-1:0]   remaining;
  logic [EV_W-1:0]   captured;
  logic [EV_W-1:0]   pending_next;
  logic [CODE_W-1:0] next_code;
  logic              next_any;
  logic              accept;

  assign accept = valid & ready;

  always_comb begin
    taken = '0;
    if (accept) taken[code] = 1'b1;
  end

  // Events arriving this cycle are not in 'remaining', so they only become
  // eligible for presentation from the next edge.
  assign remaining    = pending & ~taken;
  assign captured     = en ? ev : '0;
  // Set wins over clear: a bit accepted and re-raised in the same cycle stays.
  assign pending_next = clr ? '0 : (remaining | captured);

  // In IDLE valid is 0, so taken is 0 and 'remaining' equals 'pending': one
  // encoder serves both the first load and the back-to-back reload.
  prio_enc8 u_enc (
    .vec (remaining),
    .idx (next_code),
    .any (next_any)
  );

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      code    <= '0;
      valid   <= 1'b0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else begin
      pending <= pending_next;
      cnt     <= popcount(pending_next);

      if (clr) begin
        ovf <= 1'b0;
      end else if (|(captured & remaining)) begin
        ovf <= 1'b1;
      end

      if (clr) begin
        // Clear overrides a simultaneous accept; the presentation is dropped.
        state <= IDLE;
        valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (next_any) begin
              code  <= next_code;
              valid <= 1'b1;
              state <= PRESENT;
            end
          end
          PRESENT: begin
            // Without an accept, code and valid hold; later higher-priority
            // arrivals wait for the current transfer to finish.
            if (accept) begin
              if (next_any) begin
                code <= next_code;
              end else begin
                valid <= 1'b0;
                state <= IDLE;
              end
            end
          end
          default: begin
            valid <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_event_encoder.sv
// -----------------------------------------------------------------------------
// tb_event_encoder
// Directed bench for event_encoder. Expected codes are queued when events are
// driven and compared whenever the DUT completes a valid & ready transfer.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_event_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] ev;
  logic       en;
  logic       clr;
  logic [2:0] code;
  logic       valid;
  logic       ready;
  logic [3:0] cnt;
  logic       ovf;

  int         n_vec  = 0;
  int         n_miss = 0;
  logic [2:0] exp_q[$];

  event_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ev    (ev),
    .en    (en),
    .clr   (clr),
    .code  (code),
    .valid (valid),
    .ready (ready),
    .cnt   (cnt),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle. A transfer happening at this edge is scored first.
  task automatic tick();
    logic [2:0] e;
    if (valid === 1'b1 && ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", {5'd0, code}, 8'hEE);
      end else begin
        e = exp_q.pop_front();
        chk("transfer_code", {5'd0, code}, {5'd0, e});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ev = '0; en = 1'b1; clr = 1'b0; ready = 1'b0;
    #3;
    chk("reset_valid", {7'd0, valid}, 8'd0);
    chk("reset_code",  {5'd0, code},  8'd0);
    chk("reset_cnt",   {4'd0, cnt},   8'd0);
    chk("reset_ovf",   {7'd0, ovf},   8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single event: two-edge latency, one transfer.
    ev = 8'h10; ready = 1'b1; exp_q.push_back(3'd4);
    tick();
    ev = '0;
    chk("single_edge1_valid", {7'd0, valid}, 8'd0);
    chk("single_edge1_cnt",   {4'd0, cnt},   8'd1);
    tick();
    chk("single_valid", {7'd0, valid}, 8'd1);
    chk("single_code",  {5'd0, code},  8'd4);
    chk("single_cnt",   {4'd0, cnt},   8'd1);
    tick();
    chk("single_done_valid", {7'd0, valid}, 8'd0);
    chk("single_done_cnt",   {4'd0, cnt},   8'd0);

    // Priority and back-to-back transfers.
    ev = 8'h85; exp_q.push_back(3'd7); exp_q.push_back(3'd2); exp_q.push_back(3'd0);
    tick();
    ev = '0;
    chk("b2b_cnt_capture", {4'd0, cnt}, 8'd3);
    tick();
    chk("b2b_code7", {5'd0, code}, 8'd7);
    chk("b2b_cnt3",  {4'd0, cnt},  8'd3);
    tick();
    chk("b2b_code2", {5'd0, code}, 8'd2);
    chk("b2b_cnt2",  {4'd0, cnt},  8'd2);
    tick();
    chk("b2b_code0", {5'd0, code}, 8'd0);
    chk("b2b_valid", {7'd0, valid}, 8'd1);
    chk("b2b_cnt1",  {4'd0, cnt},  8'd1);
    tick();
    chk("b2b_end_valid", {7'd0, valid}, 8'd0);
    chk("b2b_cnt0",      {4'd0, cnt},   8'd0);

    // Stall stability: a later higher-priority event must not preempt.
    ready = 1'b0; ev = 8'h02; exp_q.push_back(3'd1);
    tick();
    ev = '0;
    tick();
    chk("stall_code_first", {5'd0, code}, 8'd1);
    for (int i = 0; i < 5; i++) begin
      ev = (i == 2) ? 8'h80 : 8'h00;
      if (i == 2) exp_q.push_back(3'd7);
      tick();
      chk("stall_code_hold",  {5'd0, code},  8'd1);
      chk("stall_valid_hold", {7'd0, valid}, 8'd1);
    end
    chk("stall_cnt", {4'd0, cnt}, 8'd2);
    ready = 1'b1;
    tick();
    chk("stall_code_next", {5'd0, code}, 8'd7);
    tick();
    chk("stall_end_valid", {7'd0, valid}, 8'd0);

    // Set wins over clear in the accept cycle; ovf only on a true overlap.
    ready = 1'b0; ev = 8'h08; exp_q.push_back(3'd3);
    tick();
    ev = '0;
    tick();
    chk("setwin_code", {5'd0, code}, 8'd3);
    ready = 1'b1; ev = 8'h08; exp_q.push_back(3'd3);
    tick();
    ready = 1'b0; ev = '0;
    chk("setwin_ovf",   {7'd0, ovf}, 8'd0);
    chk("setwin_cnt",   {4'd0, cnt}, 8'd1);
    tick();
    chk("setwin_repres_valid", {7'd0, valid}, 8'd1);
    chk("setwin_repres_code",  {5'd0, code},  8'd3);
    ev = 8'h08;
    tick();
    ev = '0;
    chk("ovf_set", {7'd0, ovf}, 8'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("ovf_sticky",      {7'd0, ovf},   8'd1);
    chk("ovf_drain_valid", {7'd0, valid}, 8'd0);

    // Clear and enable.
    ev = 8'hFF;
    tick();
    ev = '0;
    chk("full_cnt", {4'd0, cnt}, 8'd8);
    tick();
    chk("full_code", {5'd0, code}, 8'd7);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_valid", {7'd0, valid}, 8'd0);
    chk("clr_cnt",   {4'd0, cnt},   8'd0);
    chk("clr_ovf",   {7'd0, ovf},   8'd0);
    en = 1'b0; ev = 8'hFF;
    tick();
    chk("en0_cnt", {4'd0, cnt}, 8'd0);
    tick();
    chk("en0_valid", {7'd0, valid}, 8'd0);
    chk("en0_ovf",   {7'd0, ovf},   8'd0);
    en = 1'b1; ev = '0;

    // Asynchronous reset during a presentation of code 5.
    ev = 8'h20;
    tick();
    ev = '0;
    tick();
    chk("prerst_code", {5'd0, code}, 8'd5);
    ev = 8'h20;
    tick();
    ev = '0;
    chk("prerst_ovf", {7'd0, ovf}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", {7'd0, valid}, 8'd0);
    chk("rst_code",  {5'd0, code},  8'd0);
    chk("rst_cnt",   {4'd0, cnt},   8'd0);
    chk("rst_ovf",   {7'd0, ovf},   8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("postrst_valid", {7'd0, valid}, 8'd0);

    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
